// File: rtl/id_imm_queue.sv
// Decode-stage immediate queue: classifies each fetched RV32 opcode, sign-extends its
// immediate and buffers {inst, pc, imm, format, illegal} in a 2-entry registered FIFO.
module id_imm_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_ext_op,
  output logic        out_illegal
);

  localparam logic [2:0] EXT_NONE = 3'd0;
  localparam logic [2:0] EXT_I    = 3'd1;
  localparam logic [2:0] EXT_S    = 3'd2;
  localparam logic [2:0] EXT_B    = 3'd3;
  localparam logic [2:0] EXT_J    = 3'd4;
  localparam logic [2:0] EXT_U    = 3'd5;

  localparam logic [1:0] COUNT_FULL = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  ext_op;
    logic        illegal;
  } entry_t;

  entry_t      r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_in_ready;

  logic [2:0]  w_ext_op;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_next;

  // Opcode classification.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ext_op  = EXT_NONE;
    w_illegal = 1'b0;
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: w_ext_op = EXT_I;
      7'b0100011:                         w_ext_op = EXT_S;
      7'b1100011:                         w_ext_op = EXT_B;
      7'b1101111:                         w_ext_op = EXT_J;
      7'b0110111, 7'b0010111:             w_ext_op = EXT_U;
      7'b0110011:                         w_ext_op = EXT_NONE;
      default:                            w_illegal = 1'b1;
    endcase
  end

  // Immediate sign-extender driven by the classified format.
  always_comb begin
    w_imm = '0;
    case (w_ext_op)
      EXT_I: w_imm = {{20{in_inst[31]}}, in_inst[31:20]};
      EXT_S: w_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      EXT_B: w_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
      EXT_J: w_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
      EXT_U: w_imm = {in_inst[31:12], 12'b0};
      default: w_imm = '0;
    endcase
  end

  assign w_push = in_valid & r_in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + 2'd1;
        2'b01:   w_count_next = r_count - 2'd1;
        default: w_count_next = r_count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: entry storage is reset too, so head fields read 0 while the queue is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next != COUNT_FULL);
      if (flush) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= '{inst: in_inst, pc: in_pc, imm: w_imm,
                               ext_op: w_ext_op, illegal: w_illegal};
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_inst    = r_mem[r_rd_ptr].inst;
  assign out_pc      = r_mem[r_rd_ptr].pc;
  assign out_imm     = r_mem[r_rd_ptr].imm;
  assign out_ext_op  = r_mem[r_rd_ptr].ext_op;
  assign out_illegal = r_mem[r_rd_ptr].illegal;

endmodule

// File: tb/tb_id_imm_queue.sv
// Directed bench for id_imm_queue: formats, backpressure, streaming wrap-around,
// flush, classification edge cases and asynchronous reset mid-stream.
module tb_id_imm_queue;

  localparam logic [2:0] EXT_I = 3'd1;
  localparam logic [2:0] EXT_S = 3'd2;
  localparam logic [2:0] EXT_B = 3'd3;
  localparam logic [2:0] EXT_J = 3'd4;
  localparam logic [2:0] EXT_U = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_ext_op;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_imm_queue #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .out_imm    (out_imm),
    .out_ext_op (out_ext_op),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] fmt_inst [5];
  logic [31:0] fmt_imm  [5];
  logic [2:0]  fmt_ext  [5];

  initial begin
    fmt_inst[0] = 32'hFFF00093; fmt_imm[0] = 32'hFFFFFFFF; fmt_ext[0] = EXT_I;
    fmt_inst[1] = 32'h00112623; fmt_imm[1] = 32'h0000000C; fmt_ext[1] = EXT_S;
    fmt_inst[2] = 32'hFE000EE3; fmt_imm[2] = 32'hFFFFFFFC; fmt_ext[2] = EXT_B;
    fmt_inst[3] = 32'h0080006F; fmt_imm[3] = 32'h00000008; fmt_ext[3] = EXT_J;
    fmt_inst[4] = 32'h123452B7; fmt_imm[4] = 32'h12345000; fmt_ext[4] = EXT_U;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;

    // Reset state, held across edges.
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    tick(); tick();
    check("rst_hold_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
    tick();
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_out_valid", 32'(out_valid), 32'd0);

    // Formats streamed one per cycle with out_ready high.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_inst = fmt_inst[k]; in_pc = 32'h100 + 32'(4 * k);
      tick();
      check($sformatf("fmt%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("fmt%0d_imm", k), out_imm, fmt_imm[k]);
      check($sformatf("fmt%0d_ext", k), 32'(out_ext_op), 32'(fmt_ext[k]));
      check($sformatf("fmt%0d_pc", k), out_pc, 32'h100 + 32'(4 * k));
      check($sformatf("fmt%0d_ready", k), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("fmt_drained", 32'(out_valid), 32'd0);

    // Backpressure: two accepted, third held off until the first pop.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h200;
    tick();
    check("bp_ready_after_1", 32'(in_ready), 32'd1);
    in_pc = 32'h204;
    tick();
    check("bp_ready_after_2", 32'(in_ready), 32'd0);
    in_pc = 32'h208;
    tick();
    check("bp_ready_full", 32'(in_ready), 32'd0);
    check("bp_head_a", out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    check("bp_head_b", out_pc, 32'h204);
    tick();
    in_valid = 1'b0;
    check("bp_head_c", out_pc, 32'h208);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count=1 for ten cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h300;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_pc = 32'h300 + 32'(4 * i);
      tick();
      check($sformatf("stream%0d_pc", i), out_pc, 32'h300 + 32'(4 * i));
      check($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
    end
    check("stream_valid", 32'(out_valid), 32'd1);

    // Flush while full with an instruction on offer.
    out_ready = 1'b0;
    in_pc = 32'h400;
    tick();
    check("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1; in_pc = 32'h500;
    tick();
    flush = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    in_pc = 32'h504;
    tick();
    in_valid = 1'b0;
    check("fl_next_pc", out_pc, 32'h504);
    out_ready = 1'b1;
    tick();
    check("fl_drained", 32'(out_valid), 32'd0);

    // Classification corner cases.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000033; in_pc = 32'h600;
    tick();
    check("add_imm", out_imm, 32'd0);
    check("add_ext", 32'(out_ext_op), 32'd0);
    check("add_illegal", 32'(out_illegal), 32'd0);
    out_ready = 1'b1; in_inst = 32'h0000007F; in_pc = 32'h604;
    tick();
    check("ill_illegal", 32'(out_illegal), 32'd1);
    check("ill_imm", out_imm, 32'd0);
    check("ill_ext", 32'(out_ext_op), 32'd0);
    in_inst = 32'hFFFFFFB3; in_pc = 32'h608;
    tick();
    check("add1s_imm", out_imm, 32'd0);
    check("add1s_illegal", 32'(out_illegal), 32'd0);
    check("add1s_inst", out_inst, 32'hFFFFFFB3);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-stream with the queue full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h700;
    tick();
    in_pc = 32'h704;
    tick();
    in_valid = 1'b0;
    check("ar_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_pc", out_pc, 32'd0);
    check("ar_out_imm", out_imm, 32'd0);
    check("ar_out_inst", out_inst, 32'd0);
    tick();
    #4 rst_n = 1'b1;
    #1 check("ar_ready_pre_edge", 32'(in_ready), 32'd0);
    tick();
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_empty", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_inst = 32'h0080006F; in_pc = 32'h800;
    tick();
    in_valid = 1'b0;
    check("ar_push_pc", out_pc, 32'h800);
    check("ar_push_imm", out_imm, 32'h00000008);
    out_ready = 1'b1;
    tick();
    check("ar_drained", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_imm_queue.md
# id_imm_queue

Decode-stage immediate queue for the RV32 pipeline. It accepts fetched instructions over a valid/ready handshake and classifies each opcode into an extension format. It drives the existing immediate sign-extender with that format and stores the result with the instruction in a 2-entry FIFO. The FIFO feeds the ID/EX boundary through a registered valid/ready output, decoupling fetch from execute stalls without a combinational ready path.

## Interface
- DEPTH, 2, FIFO entries; only 2 is supported.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of all queued entries (branch redirect).
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept; registered, equals !full.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ID/EX accepts head.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- out_imm  out  32  head extended immediate.
- out_ext_op  out  3  head format (`EXT_I/S/B/J/U`, or 0 for none).
- out_illegal  out  1  head opcode unrecognised.

## Operation
- Opcode (inst[6:0]) to format:
  - 0010011, 0000011, 1100111 -> `EXT_I`
  - 0100011 -> `EXT_S`
  - 1100011 -> `EXT_B`
  - 1101111 -> `EXT_J`
  - 0110111, 0010111 -> `EXT_U`
  - 0110011 -> 3'b000, imm 0, legal
  - Any other opcode -> 3'b000, imm 0, illegal=1
- Classification and extension are combinational on in_inst. The results are written into the entry at enqueue, so outputs come straight from storage registers.
- Storage: 2 entries of {inst, pc, imm, ext_op, illegal}, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- Push = in_valid & in_ready & !flush.
- Pop = out_valid & out_ready & !flush.
- Push and pop in the same cycle: count unchanged; both pointers advance; order preserved.
- Full (count=2): in_ready=0; in_valid is ignored.
- Empty (count=0): out_valid=0. Head fields are don't-care but stable.
- flush: count:=0, wr_ptr:=0, rd_ptr:=0. Flush wins over a push or pop in the same cycle, and that instruction is dropped.
- Pointers wrap 1->0. Count never exceeds 2 or goes below 0.
- Reset (async, any time, including mid-transfer): count=0, pointers=0, in_ready=0 while rst_n=0. Entry storage is cleared to 0, so out_inst/pc/imm/ext_op/illegal read 0.

## Timing
- in_ready is a register: 1 from the first edge after rst_n deasserts, then !full of the post-edge count.
- Latency: an instruction pushed at edge N has out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle sustained when out_ready=1 continuously.
- No combinational path from out_ready to in_ready.
- out_valid and head fields are registered/mux-from-register; they change only on clock edges or reset.
- Reset values: in_ready=0, out_valid=0, all data outputs 0.

## Test plan
- Formats: push 0xFFF00093 (addi -1), 0x00112623 (sw 12), 0xFE000EE3 (beq -4), 0x0080006F (jal 8), 0x123452B7 (lui) with out_ready=1.
  - Required out_imm in order: 0xFFFFFFFF, 0x0000000C, 0xFFFFFFFC, 0x00000008, 0x12345000.
  - Required ext_op in order: I, S, B, J, U.
  - One per cycle, 1-cycle latency.
- Backpressure: out_ready=0, push 3 instructions.
  - First two accepted; in_ready=0 after the second.
  - Release out_ready: outputs appear in order, and in_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at count=1 for 10 cycles: count stays 1, wrap-around exercised, PCs sequential with no loss or duplication.
- Flush with count=2 and in_valid=1 in the same cycle: next cycle out_valid=0, in_ready=1; the offered instruction is not queued.
- Classification: 0x00000033 (add) -> imm 0, ext_op 0, illegal=0. 0x0000007F -> illegal=1, imm 0.
- Reset: assert rst_n=0 mid-stream with count=2. Outputs go to 0 asynchronously; after release, in_ready=1 one edge later and the queue is empty.
